// File: rtl/nonce_search_ctrl_pkg.sv
// Shared mining definitions: widths, search states and the target check.
// Used by the nonce search controller, its comparator and the bench.
package mining_pkg;

    localparam int NONCE_W   = 32;
    localparam int HDR_BYTES = 12;
    localparam int HASH_W    = 24;
    localparam int TARGET_W  = 8;
    localparam int HDR_W     = HDR_BYTES * 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_CHECK,
        S_FOUND,
        S_EXHAUSTED
    } search_state_t;

    // Both upper result bytes must be strictly below the target.
    function automatic logic meets_target(
        input logic [HASH_W-1:0]   hash,
        input logic [TARGET_W-1:0] target
    );
        return (hash[23:16] < target) && (hash[15:8] < target);
    endfunction

endpackage

// File: rtl/nonce_search_ctrl_if.sv
// Launch/result link between the nonce search controller and the hash core.
// The controller is the master; the hash core is the slave.
interface nonce_search_ctrl_if;
    import mining_pkg::*;

    logic              hash_start;
    logic [HDR_W-1:0]  hash_header;
    logic [NONCE_W-1:0] hash_nonce;
    logic              hash_done;
    logic [HASH_W-1:0] hash_out;

    modport master (
        output hash_start,
        output hash_header,
        output hash_nonce,
        input  hash_done,
        input  hash_out
    );

    modport slave (
        input  hash_start,
        input  hash_header,
        input  hash_nonce,
        output hash_done,
        output hash_out
    );

endinterface

// File: rtl/nonce_search_ctrl_cmp.sv
// Target comparator fed by the controller's captured hash and target.
// Purely combinational; its inputs are already registered upstream.
module pow_target_cmp
    import mining_pkg::*;
(
    input  logic [HASH_W-1:0]   i_hash,
    input  logic [TARGET_W-1:0] i_target,
    output logic                o_meets
);

    assign o_meets = meets_target(i_hash, i_target);

endmodule

// File: rtl/nonce_search_ctrl.sv
// Proof-of-work nonce search sequencer driving one hash core.
// Optional NONCE_SEARCH_ATTEMPT_CNT_EN adds an attempts counter output.
module nonce_search_ctrl
    import mining_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [HDR_W-1:0]    header_in,
    input  logic [TARGET_W-1:0] target_in,
    input  logic [NONCE_W-1:0]  nonce_start,
    input  logic [NONCE_W-1:0]  nonce_limit,
    nonce_search_ctrl_if.master hc,
    output logic                busy,
    output logic                done,
    output logic                found,
    output logic [NONCE_W-1:0]  nonce_out,
    output logic [HASH_W-1:0]   hash_match
`ifdef NONCE_SEARCH_ATTEMPT_CNT_EN
    ,
    output logic [NONCE_W:0]    attempts
`endif
);

    search_state_t       r_state;
    logic [HDR_W-1:0]    r_header;
    logic [TARGET_W-1:0] r_target;
    logic [NONCE_W-1:0]  r_limit;
    logic [NONCE_W-1:0]  r_nonce_cur;
    logic [HASH_W-1:0]   r_hash_q;
    logic                r_hash_start;
    logic [NONCE_W-1:0]  r_hash_nonce;
    logic                r_busy;
    logic                r_done;
    logic                r_found;
    logic [NONCE_W-1:0]  r_nonce_out;
    logic [HASH_W-1:0]   r_hash_match;
    logic                w_meets;
    logic [NONCE_W-1:0]  w_nonce_nxt;

    assign w_nonce_nxt = r_nonce_cur + 32'd1;

    pow_target_cmp u_cmp (
        .i_hash   (r_hash_q),
        .i_target (r_target),
        .o_meets  (w_meets)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_header     <= '0;
            r_target     <= '0;
            r_limit      <= '0;
            r_nonce_cur  <= '0;
            r_hash_q     <= '0;
            r_hash_start <= 1'b0;
            r_hash_nonce <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_found      <= 1'b0;
            r_nonce_out  <= '0;
            r_hash_match <= '0;
        end else begin
            r_hash_start <= 1'b0;
            r_done       <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_header     <= header_in;
                        r_target     <= target_in;
                        r_limit      <= nonce_limit;
                        r_nonce_cur  <= nonce_start;
                        r_hash_nonce <= nonce_start;
                        r_hash_start <= 1'b1;
                        r_busy       <= 1'b1;
                        r_found      <= 1'b0;
                        r_nonce_out  <= '0;
                        r_hash_match <= '0;
                        r_state      <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (hc.hash_done) begin
                        r_hash_q <= hc.hash_out;
                        r_state  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_meets) begin
                        r_found      <= 1'b1;
                        r_nonce_out  <= r_nonce_cur;
                        r_hash_match <= r_hash_q;
                        r_done       <= 1'b1;
                        r_state      <= S_FOUND;
                    end else if (r_nonce_cur == r_limit) begin
                        r_done  <= 1'b1;
                        r_state <= S_EXHAUSTED;
                    end else begin
                        // Increment wraps naturally past all-ones.
                        r_nonce_cur  <= w_nonce_nxt;
                        r_hash_nonce <= w_nonce_nxt;
                        r_hash_start <= 1'b1;
                        r_state      <= S_LAUNCH;
                    end
                end
                S_FOUND, S_EXHAUSTED: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef NONCE_SEARCH_ATTEMPT_CNT_EN
    logic [NONCE_W:0] r_attempts;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_attempts <= '0;
        end else if (r_state == S_IDLE && start && !abort) begin
            r_attempts <= '0;
        end else if (r_state == S_CHECK) begin
            r_attempts <= r_attempts + (NONCE_W+1)'(1);
        end
    end

    assign attempts = r_attempts;
`endif

    assign hc.hash_start  = r_hash_start;
    assign hc.hash_header = r_header;
    assign hc.hash_nonce  = r_hash_nonce;
    assign busy           = r_busy;
    assign done           = r_done;
    assign found          = r_found;
    assign nonce_out      = r_nonce_out;
    assign hash_match     = r_hash_match;

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Bench for nonce_search_ctrl: vector table, random runs against a search model.
// Hash core is modelled with a 3-cycle result latency.
module tb_nonce_search_ctrl;
    import mining_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               abort;
    logic [HDR_W-1:0]   header_in;
    logic [7:0]         target_in;
    logic [31:0]        nonce_start;
    logic [31:0]        nonce_limit;
    logic               busy;
    logic               done;
    logic               found;
    logic [31:0]        nonce_out;
    logic [23:0]        hash_match;
`ifdef NONCE_SEARCH_ATTEMPT_CNT_EN
    logic [32:0]        attempts;
`endif

    int checks = 0;
    int failures = 0;

    nonce_search_ctrl_if hif ();

    nonce_search_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .header_in   (header_in),
        .target_in   (target_in),
        .nonce_start (nonce_start),
        .nonce_limit (nonce_limit),
        .hc          (hif),
        .busy        (busy),
        .done        (done),
        .found       (found),
        .nonce_out   (nonce_out),
        .hash_match  (hash_match)
`ifdef NONCE_SEARCH_ATTEMPT_CNT_EN
        ,
        .attempts    (attempts)
`endif
    );

    always #5 clk = ~clk;

    // Hash core model
    int          hmode = 0;
    logic [31:0] hseed = 32'h0;
    int          launches = 0;
    logic [31:0] nonce_q[$];
    logic [3:0]  d_v = '0;
    logic [31:0] d_n[4];

    function automatic logic [23:0] model_hash(input logic [31:0] n);
        logic [31:0] x;
        case (hmode)
            0: return 24'h101010;
            1: return (n == 32'd5) ? 24'h1f0a77 : 24'h401000;
            default: begin
                x = (n ^ hseed) * 32'h9E3779B1;
                return x[31:8];
            end
        endcase
    endfunction

    initial begin
        hif.hash_done = 1'b0;
        hif.hash_out  = '0;
    end

    always @(negedge clk) begin
        if (hif.hash_start === 1'b1) begin
            launches++;
            nonce_q.push_back(hif.hash_nonce);
        end
        d_v    = {d_v[2:0], hif.hash_start === 1'b1};
        d_n[3] = d_n[2];
        d_n[2] = d_n[1];
        d_n[1] = d_n[0];
        d_n[0] = hif.hash_nonce;
        hif.hash_done = d_v[3];
        hif.hash_out  = d_v[3] ? model_hash(d_n[3]) : 24'h0;
    end

    task automatic chk(input string nm, input logic [95:0] act,
                       input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Search reference: walk the range with plain arithmetic.
    task automatic ref_search(input logic [31:0] ns, input logic [31:0] nl,
                              input logic [7:0] t, output bit ef,
                              output logic [31:0] en, output logic [23:0] eh,
                              output int na);
        logic [31:0] n;
        logic [23:0] h;
        n = ns; ef = 0; en = 0; eh = 0; na = 0;
        while (1) begin
            na++;
            h = model_hash(n);
            if (h[23:16] < t && h[15:8] < t) begin
                ef = 1; en = n; eh = h;
                break;
            end
            if (n == nl) break;
            n = n + 32'd1;
        end
    endtask

    task automatic do_search(input string tag, input logic [95:0] hdr,
                             input logic [7:0] t, input logic [31:0] ns,
                             input logic [31:0] nl, input bit ef,
                             input logic [31:0] en, input logic [23:0] eh,
                             input int na);
        int cyc;
        bit seq_ok;
        @(negedge clk);
        header_in = hdr; target_in = t;
        nonce_start = ns; nonce_limit = nl;
        start = 1'b1;
        launches = 0;
        nonce_q.delete();
        cyc = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end while (done !== 1'b1 && cyc < 2000);
        chk({tag, "_done_cycle"}, 96'(cyc), 96'(5 * na + 1));
        chk({tag, "_found"}, 96'(found), 96'(ef));
        chk({tag, "_nonce_out"}, 96'(nonce_out), 96'(en));
        chk({tag, "_hash_match"}, 96'(hash_match), 96'(eh));
        chk({tag, "_hash_header"}, hif.hash_header, hdr);
        chk({tag, "_launches"}, 96'(launches), 96'(na));
        chk({tag, "_busy_at_done"}, 96'(busy), 96'(1));
`ifdef NONCE_SEARCH_ATTEMPT_CNT_EN
        chk({tag, "_attempts"}, 96'(attempts), 96'(na));
`endif
        seq_ok = (nonce_q.size() == na);
        for (int k = 0; k < nonce_q.size(); k++)
            if (nonce_q[k] !== ns + 32'(k)) seq_ok = 0;
        chk({tag, "_nonce_seq"}, 96'(seq_ok), 96'(1));
        @(negedge clk);
        chk({tag, "_busy_after"}, 96'(busy), 96'(0));
        chk({tag, "_done_pulse"}, 96'(done), 96'(0));
    endtask

    typedef struct {
        string       tag;
        int          mode;
        logic [95:0] hdr;
        logic [7:0]  tgt;
        logic [31:0] ns;
        logic [31:0] nl;
        bit          ef;
        logic [31:0] en;
        logic [23:0] eh;
        int          na;
    } vec_t;

    vec_t vecs[6];

    initial begin
        bit          ef;
        logic [31:0] en;
        logic [23:0] eh;
        int          na;
        bit          bad;
        logic [31:0] ns;
        logic [7:0]  t;

        vecs[0] = '{"basic_hit", 0, 96'h397d9f2f40ca9e6c6b1f3324, 8'hff,
                    32'hfded873c, 32'hfded8740, 1, 32'hfded873c, 24'h101010, 1};
        vecs[1] = '{"multi", 1, 96'h0123456789abcdef01234567, 8'h20,
                    32'h0, 32'd10, 1, 32'd5, 24'h1f0a77, 6};
        vecs[2] = '{"exhaust", 0, 96'hfeedface0000111122223333, 8'h00,
                    32'h10, 32'h13, 0, 32'h0, 24'h0, 4};
        vecs[3] = '{"wrap", 0, 96'h00000000000000000000beef, 8'h10,
                    32'hfffffffe, 32'h1, 0, 32'h0, 24'h0, 4};
        vecs[4] = '{"single_hit", 0, 96'h1, 8'h11,
                    32'h77, 32'h77, 1, 32'h77, 24'h101010, 1};
        vecs[5] = '{"single_miss", 0, 96'h2, 8'h10,
                    32'h77, 32'h77, 0, 32'h0, 24'h0, 1};

        reset = 1'b1; start = 1'b0; abort = 1'b0;
        header_in = '0; target_in = '0;
        nonce_start = '0; nonce_limit = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 96'(busy), 96'(0));
        chk("rst_done", 96'(done), 96'(0));
        chk("rst_found", 96'(found), 96'(0));
        chk("rst_nonce_out", 96'(nonce_out), 96'(0));
        chk("rst_hash_match", 96'(hash_match), 96'(0));
        chk("rst_hash_start", 96'(hif.hash_start), 96'(0));
        chk("rst_hash_nonce", 96'(hif.hash_nonce), 96'(0));
        chk("rst_hash_header", hif.hash_header, 96'(0));
        reset = 1'b0;

        foreach (vecs[i]) begin
            hmode = vecs[i].mode;
            do_search(vecs[i].tag, vecs[i].hdr, vecs[i].tgt, vecs[i].ns,
                      vecs[i].nl, vecs[i].ef, vecs[i].en, vecs[i].eh,
                      vecs[i].na);
        end

        // start together with abort: abort wins
        @(negedge clk);
        launches = 0;
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", 96'(busy), 96'(0));
        repeat (6) @(negedge clk);
        chk("start_abort_launch", 96'(launches), 96'(0));

        // abort during WAIT; late result must be dropped
        hmode = 0;
        @(negedge clk);
        target_in = 8'h00; nonce_start = 32'h100; nonce_limit = 32'h1ff;
        launches = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 96'(busy), 96'(0));
        bad = 0;
        repeat (8) begin
            if (done !== 1'b0 || busy !== 1'b0 || found !== 1'b0) bad = 1;
            @(negedge clk);
        end
        chk("abort_quiet", 96'(bad), 96'(0));
        chk("abort_launches", 96'(launches), 96'(1));
        hmode = vecs[1].mode;
        do_search("after_abort", vecs[1].hdr, vecs[1].tgt, vecs[1].ns,
                  vecs[1].nl, 1, 32'd5, 24'h1f0a77, 6);

        // randomized ranges against the reference search
        hmode = 2;
        for (int r = 0; r < 25; r++) begin
            hseed = $urandom();
            t = 8'($urandom_range(0, 96));
            if ($urandom_range(0, 3) == 0)
                ns = 32'hfffffff0 + 32'($urandom_range(0, 15));
            else
                ns = $urandom();
            nonce_limit = ns + 32'($urandom_range(0, 15));
            ref_search(ns, nonce_limit, t, ef, en, eh, na);
            do_search($sformatf("rand%0d", r), {$urandom(), $urandom(),
                      $urandom()}, t, ns, nonce_limit, ef, en, eh, na);
        end

        // reset in the middle of a search after a successful one
        hmode = 0;
        do_search("pre_reset", vecs[0].hdr, vecs[0].tgt, vecs[0].ns,
                  vecs[0].nl, 1, 32'hfded873c, 24'h101010, 1);
        @(negedge clk);
        target_in = 8'h00; nonce_start = 32'h5; nonce_limit = 32'h50;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_busy", 96'(busy), 96'(0));
        chk("mid_rst_found", 96'(found), 96'(0));
        chk("mid_rst_nonce_out", 96'(nonce_out), 96'(0));
        chk("mid_rst_hash_match", 96'(hash_match), 96'(0));
        chk("mid_rst_hash_header", hif.hash_header, 96'(0));
        chk("mid_rst_hash_nonce", 96'(hif.hash_nonce), 96'(0));
        bad = 0;
        repeat (8) begin
            if (done !== 1'b0 || busy !== 1'b0) bad = 1;
            @(negedge clk);
        end
        chk("mid_rst_quiet", 96'(bad), 96'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
